// File: rtl/score_keeper_pkg.sv
// rtl/score_keeper_pkg.sv - shared types and constants for the score_keeper slice
// Contents: game state enumeration, BCD digit type, BCD limits.
package score_keeper_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    CHECK = 2'd2,
    OVER  = 2'd3
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;
  localparam logic [7:0] SCORE_MAX     = 8'h99;

endpackage

// File: rtl/score_keeper_if.sv
// rtl/score_keeper_if.sv - game-control pulses and score/status outputs of score_keeper
// Signals:
//   start, point, miss : one-cycle input pulses from input conditioning
//   score, highScore   : BCD {tens, ones}
//   lives              : remaining lives, LIVES_W bits
//   playing            : high while a game is in progress
//   died, newHighScore : one-cycle end-of-game pulses for the face stage
// Modports: master drives the pulses, slave (score_keeper) drives the status.
interface score_keeper_if #(
  parameter int LIVES_W = 3
);

  logic               start;
  logic               point;
  logic               miss;
  logic [7:0]         score;
  logic [7:0]         highScore;
  logic [LIVES_W-1:0] lives;
  logic               playing;
  logic               died;
  logic               newHighScore;

  modport master (
    output start, point, miss,
    input  score, highScore, lives, playing, died, newHighScore
  );

  modport slave (
    input  start, point, miss,
    output score, highScore, lives, playing, died, newHighScore
  );

endinterface

// File: rtl/score_keeper_bcd_counter2.sv
// rtl/score_keeper_bcd_counter2.sv - two-digit BCD next-value logic for the score
// Ports:
//   cur  in  8 : present BCD value {tens, ones}
//   clr  in  1 : next value is 00 (wins over inc)
//   inc  in  1 : next value is cur + 1 in BCD
//   sat  in  1 : at 99, inc holds 99 instead of wrapping to 00
//   nxt  out 8 : next BCD value
//   wrap out 1 : inc from 99 wrapped to 00
module bcd_counter2
  import score_keeper_pkg::*;
(
  input  logic [7:0] cur,
  input  logic       clr,
  input  logic       inc,
  input  logic       sat,
  output logic [7:0] nxt,
  output logic       wrap
);

  bcd_digit_t ones;
  bcd_digit_t tens;

  always_comb begin
    ones = cur[3:0];
    tens = cur[7:4];
    nxt  = cur;
    wrap = 1'b0;
    if (clr) begin
      nxt = 8'h00;
    end else if (inc) begin
      if (cur == SCORE_MAX) begin
        if (!sat) begin
          nxt  = 8'h00;
          wrap = 1'b1;
        end
      end else if (ones == BCD_MAX_DIGIT) begin
        nxt = {tens + 4'd1, 4'd0};
      end else begin
        nxt = {tens, ones + 4'd1};
      end
    end
  end

endmodule

// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - game state, BCD score, lives and retained high score
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset (also clears highScore)
//   bus  : score_keeper_if.slave (start/point/miss in, status out)
// Build option: SCORE_SATURATE_EN defined -> score sticks at 99,
//               undefined -> 99 + 1 wraps to 00.
module score_keeper
  import score_keeper_pkg::*;
#(
  parameter int MAX_LIVES = 3,
  parameter int LIVES_W   = 3
) (
  input  logic           clk,
  input  logic           rst,
  score_keeper_if.slave  bus
);

`ifdef SCORE_SATURATE_EN
  localparam logic SCORE_SAT = 1'b1;
`else
  localparam logic SCORE_SAT = 1'b0;
`endif

  state_t             state;
  logic [7:0]         score_q;
  logic [7:0]         high_q;
  logic [LIVES_W-1:0] lives_q;
  logic               playing_q;
  logic               died_q;
  logic               new_high_q;

  logic [7:0]         score_nxt;
  logic               score_clr;
  logic               score_inc;
  // The wrapped value itself feeds the end-of-game compare, so the flag has no consumer here.
  logic               score_wrap_unused;

  assign score_clr = bus.start && (state == IDLE || state == OVER);
  assign score_inc = bus.point && (state == PLAY);

  bcd_counter2 u_score (
    .cur  (score_q),
    .clr  (score_clr),
    .inc  (score_inc),
    .sat  (SCORE_SAT),
    .nxt  (score_nxt),
    .wrap (score_wrap_unused)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      score_q    <= 8'h00;
      high_q     <= 8'h00;
      lives_q    <= '0;
      playing_q  <= 1'b0;
      died_q     <= 1'b0;
      new_high_q <= 1'b0;
    end else begin
      // Pulses default low so they last exactly one cycle even if OVER persists.
      died_q     <= 1'b0;
      new_high_q <= 1'b0;
      // The counter holds its value unless cleared on start or incremented in PLAY.
      score_q    <= score_nxt;
      case (state)
        IDLE, OVER: begin
          if (bus.start) begin
            state     <= PLAY;
            lives_q   <= LIVES_W'(MAX_LIVES);
            playing_q <= 1'b1;
          end
        end
        PLAY: begin
          if (bus.miss) begin
            lives_q <= lives_q - LIVES_W'(1);
            if (lives_q == LIVES_W'(1)) begin
              state     <= CHECK;
              playing_q <= 1'b0;
            end
          end
        end
        CHECK: begin
          // Valid two-digit BCD orders the same as plain unsigned binary.
          if (score_q > high_q) begin
            high_q     <= score_q;
            new_high_q <= 1'b1;
          end
          died_q <= 1'b1;
          state  <= OVER;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.score        = score_q;
  assign bus.highScore    = high_q;
  assign bus.lives        = lives_q;
  assign bus.playing      = playing_q;
  assign bus.died         = died_q;
  assign bus.newHighScore = new_high_q;

endmodule

// File: tb/tb_score_keeper.sv
// tb/tb_score_keeper.sv - self-checking bench for score_keeper
module tb_score_keeper;

  localparam int MAX_LIVES = 3;
  localparam int LIVES_W   = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  score_keeper_if #(.LIVES_W(LIVES_W)) bus ();

  score_keeper #(.MAX_LIVES(MAX_LIVES), .LIVES_W(LIVES_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    to_bcd = 8'(((v / 10) * 16) + (v % 10));
  endfunction

  // Game model in plain integers: score 0..99, lives count, and a single
  // "judging" flag for the one cycle between the last miss and game over.
  int m_score = 0;
  int m_high  = 0;
  int m_lives = 0;
  bit m_play  = 1'b0;
  bit m_judge = 1'b0;
  bit m_died  = 1'b0;
  bit m_nhs   = 1'b0;

  always @(posedge clk or negedge rst) begin : model
    int s, h, l;
    bit p, j, d, n;
    if (!rst) begin
      m_score <= 0; m_high <= 0; m_lives <= 0;
      m_play <= 1'b0; m_judge <= 1'b0; m_died <= 1'b0; m_nhs <= 1'b0;
    end else begin
      s = m_score; h = m_high; l = m_lives; p = m_play; j = m_judge;
      d = 1'b0; n = 1'b0;
      if (j) begin
        if (s > h) begin h = s; n = 1'b1; end
        d = 1'b1;
        j = 1'b0;
      end else if (p) begin
        if (bus.point) begin
`ifdef SCORE_SATURATE_EN
          s = (s == 99) ? 99 : s + 1;
`else
          s = (s + 1) % 100;
`endif
        end
        if (bus.miss) begin
          l = l - 1;
          if (l == 0) begin p = 1'b0; j = 1'b1; end
        end
      end else if (bus.start) begin
        p = 1'b1; s = 0; l = MAX_LIVES;
      end
      m_score <= s; m_high <= h; m_lives <= l; m_play <= p;
      m_judge <= j; m_died <= d; m_nhs <= n;
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("cyc_score",   bus.score,        to_bcd(m_score));
      chk("cyc_high",    bus.highScore,    to_bcd(m_high));
      chk("cyc_lives",   bus.lives,        32'(m_lives));
      chk("cyc_playing", bus.playing,      m_play);
      chk("cyc_died",    bus.died,         m_died);
      chk("cyc_newhigh", bus.newHighScore, m_nhs);
    end
  end

  task automatic step(input bit s, input bit p, input bit m);
    bus.start = s; bus.point = p; bus.miss = m;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.point = 1'b0; bus.miss = 1'b0;
  endtask

  task automatic play_game(input int pts);
    step(1, 0, 0);
    for (int i = 0; i < pts; i++) step(0, 1, 0);
    for (int i = 0; i < MAX_LIVES; i++) step(0, 0, 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_score"},   bus.score,        32'h00);
    chk({tag, "_high"},    bus.highScore,    32'h00);
    chk({tag, "_lives"},   bus.lives,        32'h0);
    chk({tag, "_playing"}, bus.playing,      32'h0);
    chk({tag, "_died"},    bus.died,         32'h0);
    chk({tag, "_newhigh"}, bus.newHighScore, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.point = 1'b0; bus.miss = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b1;
    cmp_on = 1'b1;

    // Game 1: 3 points, 3 misses -> new high 03, pulse two cycles after last miss.
    play_game(3);
    @(negedge clk);
    chk("g1_check_died", bus.died, 32'h0);
    chk("g1_check_playing", bus.playing, 32'h0);
    chk("g1_check_lives", bus.lives, 32'h0);
    @(negedge clk);
    chk("g1_died", bus.died, 32'h1);
    chk("g1_newhigh", bus.newHighScore, 32'h1);
    chk("g1_high", bus.highScore, 32'h03);
    chk("g1_score", bus.score, 32'h03);
    @(negedge clk);
    chk("g1_died_width", bus.died, 32'h0);
    chk("g1_newhigh_width", bus.newHighScore, 32'h0);

    // Game 2: tie at 03 -> died but no new high.
    play_game(3);
    @(negedge clk);
    @(negedge clk);
    chk("g2_died", bus.died, 32'h1);
    chk("g2_newhigh_tie", bus.newHighScore, 32'h0);
    chk("g2_high", bus.highScore, 32'h03);

    // Game 3: point and final miss together; restart in OVER entry cycle.
    step(1, 0, 0);
    repeat (3) step(0, 1, 0);
    repeat (2) step(0, 0, 1);
    step(0, 1, 1);
    step(0, 0, 0);
    @(negedge clk);
    chk("g3_died", bus.died, 32'h1);
    chk("g3_newhigh", bus.newHighScore, 32'h1);
    chk("g3_high", bus.highScore, 32'h04);
    chk("g3_score", bus.score, 32'h04);
    step(1, 0, 0);
    @(negedge clk);
    chk("restart_playing", bus.playing, 32'h1);
    chk("restart_died", bus.died, 32'h0);
    chk("restart_score", bus.score, 32'h00);
    chk("restart_lives", bus.lives, 32'(MAX_LIVES));
    chk("restart_high", bus.highScore, 32'h04);

    // start during PLAY and during CHECK is ignored.
    step(0, 1, 0);
    step(1, 0, 0);
    @(negedge clk);
    chk("start_in_play_score", bus.score, 32'h01);
    chk("start_in_play_lives", bus.lives, 32'(MAX_LIVES));
    repeat (3) step(0, 0, 1);
    step(1, 0, 0);
    @(negedge clk);
    chk("start_in_check_died", bus.died, 32'h1);
    chk("start_in_check_playing", bus.playing, 32'h0);
    @(negedge clk);
    chk("start_in_check_over", bus.playing, 32'h0);

    // Build high score 40, then reset asynchronously mid-game at score 25.
    play_game(40);
    repeat (3) step(0, 0, 0);
    chk("high_40", bus.highScore, 32'h40);
    step(1, 0, 0);
    repeat (25) step(0, 1, 0);
    @(negedge clk);
    chk("pre_reset_score", bus.score, 32'h25);
    #2 rst = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    @(negedge clk);
    rst = 1'b1;
    repeat (3) step(0, 1, 0);
    @(negedge clk);
    chk("idle_point_score", bus.score, 32'h00);
    chk("idle_point_playing", bus.playing, 32'h0);

    // Long run across the tens carry and the 99 boundary.
    step(1, 0, 0);
    for (int i = 1; i <= 101; i++) begin
      step(0, 1, 0);
      @(negedge clk);
      if (i == 9)  chk("bcd_09", bus.score, 32'h09);
      if (i == 10) chk("bcd_10", bus.score, 32'h10);
`ifdef SCORE_SATURATE_EN
      if (i == 100) chk("bcd_100th", bus.score, 32'h99);
      if (i == 101) chk("bcd_101st", bus.score, 32'h99);
`else
      if (i == 100) chk("bcd_100th", bus.score, 32'h00);
      if (i == 101) chk("bcd_101st", bus.score, 32'h01);
`endif
    end
    repeat (3) step(0, 0, 1);
    repeat (3) step(0, 0, 0);
`ifdef SCORE_SATURATE_EN
    chk("final_high", bus.highScore, 32'h99);
`else
    chk("final_high", bus.highScore, 32'h01);
`endif

    @(negedge clk);
    cmp_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
